player_missile_ctrl: RTL and testbench

Player missile controller. Sits directly downstream of the ship-location stage: consumes its ship position and the USB keycode, spawns player missiles from the ship nose on Space, and advances them upward once per frame. Drives per-pixel missile visibility to the colour mapper and missile positions to enemy collision logic, which returns per-slot hit strobes.

---
 rtl/player_missile_ctrl.sv | 129 ++++++++++++
 tb/tb_player_missile_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_missile_ctrl.sv
// Player missile controller: spawns missiles from the ship nose on a fresh Space press,
// moves them up once per frame, retires them at the top or on a hit, and renders them per pixel.
module player_missile_ctrl #(
  parameter int unsigned NUM_SLOTS    = 2,
  parameter int unsigned MISSILE_STEP = 4,
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned NOSE_OFFSET  = 7,
  parameter int unsigned MISSILE_W    = 2,
  parameter int unsigned MISSILE_H    = 6,
  parameter int unsigned Y_MIN        = 0,
  parameter logic [7:0]  SPACE_CODE   = 8'h2C
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [15:0]             keycode,
  input  logic [9:0]              ShipX,
  input  logic [9:0]              ShipY,
  input  logic                    ShipColl,
  input  logic [NUM_SLOTS-1:0]    MissileHit,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic [NUM_SLOTS-1:0]    MissileActive,
  output logic [10*NUM_SLOTS-1:0] MissileXs,
  output logic [10*NUM_SLOTS-1:0] MissileYs,
  output logic                    Fired,
  output logic                    MissileOn,
  output logic [9:0]              MissileDistX,
  output logic [9:0]              MissileDistY
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CD_W    = $clog2(COOLDOWN + 2);
  localparam logic [COORD_W-1:0] RETIRE_Y = COORD_W'(Y_MIN + MISSILE_STEP);

  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [COORD_W-1:0]   x_q [NUM_SLOTS];
  logic [COORD_W-1:0]   x_d [NUM_SLOTS];
  logic [COORD_W-1:0]   y_q [NUM_SLOTS];
  logic [COORD_W-1:0]   y_d [NUM_SLOTS];
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 space_prev_q, space_prev_d;
  logic                 fired_q, fired_d;
  logic                 space_now_c;
  logic                 fire_ok_c;
  logic                 pix_found_c;

  // Frame update: existing missiles move/retire first; a fire lands in the lowest slot free at frame start
  always_comb begin
    active_d     = active_q;
    x_d          = x_q;
    y_d          = y_q;
    fired_d      = 1'b0;
    cd_d         = cd_q;
    space_now_c  = (keycode[7:0] == SPACE_CODE) || (keycode[15:8] == SPACE_CODE);
    space_prev_d = space_now_c;
    fire_ok_c    = space_now_c && !space_prev_q && (cd_q == '0) && !ShipColl &&
                   (ShipY >= COORD_W'(MISSILE_H));

    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (active_q[i]) begin
        if (MissileHit[i]) begin
          active_d[i] = 1'b0;
        end else if (y_q[i] < RETIRE_Y) begin
          active_d[i] = 1'b0;
        end else begin
          y_d[i] = y_q[i] - COORD_W'(MISSILE_STEP);
        end
      end else if (fire_ok_c && !fired_d) begin
        active_d[i] = 1'b1;
        x_d[i]      = ShipX + COORD_W'(NOSE_OFFSET);
        y_d[i]      = ShipY - COORD_W'(MISSILE_H);
        fired_d     = 1'b1;
      end
    end

    if (fired_d) begin
      cd_d = CD_W'(COOLDOWN);
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active_q     <= '0;
      cd_q         <= '0;
      space_prev_q <= 1'b0;
      fired_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q     <= active_d;
      cd_q         <= cd_d;
      space_prev_q <= space_prev_d;
      fired_q      <= fired_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  // Pixel coverage; the lowest-index covering slot supplies the in-missile offset
  always_comb begin
    pix_found_c  = 1'b0;
    MissileOn    = 1'b0;
    MissileDistX = '0;
    MissileDistY = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!pix_found_c && active_q[i] &&
          (DrawX >= x_q[i]) && (DrawX < COORD_W'(x_q[i] + COORD_W'(MISSILE_W))) &&
          (DrawY >= y_q[i]) && (DrawY < COORD_W'(y_q[i] + COORD_W'(MISSILE_H)))) begin
        pix_found_c  = 1'b1;
        MissileOn    = 1'b1;
        MissileDistX = DrawX - x_q[i];
        MissileDistY = DrawY - y_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign MissileXs[COORD_W*g +: COORD_W] = x_q[g];
    assign MissileYs[COORD_W*g +: COORD_W] = y_q[g];
  end

  assign MissileActive = active_q;
  assign Fired         = fired_q;

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Bench for player_missile_ctrl: directed scenarios then randomized frames, all checked
// against an integer reference model of the missile rules.
module tb_player_missile_ctrl;

  localparam int NUM = 2;

  logic            frame_clk;
  logic            Reset;
  logic [15:0]     keycode;
  logic [9:0]      ShipX, ShipY;
  logic            ShipColl;
  logic [NUM-1:0]  MissileHit;
  logic [9:0]      DrawX, DrawY;
  logic [NUM-1:0]  MissileActive;
  logic [10*NUM-1:0] MissileXs, MissileYs;
  logic            Fired, MissileOn;
  logic [9:0]      MissileDistX, MissileDistY;

  int checks = 0;
  int errors = 0;
  int hw_fires = 0;

  bit m_act [NUM];
  int m_x   [NUM];
  int m_y   [NUM];
  int m_cd;
  bit m_prev;
  bit m_fired;

  player_missile_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .ShipX        (ShipX),
    .ShipY        (ShipY),
    .ShipColl     (ShipColl),
    .MissileHit   (MissileHit),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .MissileActive(MissileActive),
    .MissileXs    (MissileXs),
    .MissileYs    (MissileYs),
    .Fired        (Fired),
    .MissileOn    (MissileOn),
    .MissileDistX (MissileDistX),
    .MissileDistY (MissileDistY)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_cd    = 0;
    m_prev  = 1'b0;
    m_fired = 1'b0;
  endfunction

  // One frame of the missile rules, using plain integers
  function automatic void model_edge(input logic [15:0] kc, input int sx, input int sy,
                                     input bit coll, input logic [NUM-1:0] hit);
    bit space;
    bit ok;
    int free;
    space = (kc[7:0] == 8'h2C) || (kc[15:8] == 8'h2C);
    free  = -1;
    for (int i = 0; i < NUM; i++)
      if (!m_act[i] && free < 0) free = i;
    ok = space && !m_prev && m_cd == 0 && !coll && free >= 0 && sy >= 6;
    for (int i = 0; i < NUM; i++) begin
      if (m_act[i]) begin
        if (hit[i])        m_act[i] = 1'b0;
        else if (m_y[i] < 4) m_act[i] = 1'b0;
        else               m_y[i] = m_y[i] - 4;
      end
    end
    if (ok) begin
      m_act[free] = 1'b1;
      m_x[free]   = (sx + 7) % 1024;
      m_y[free]   = sy - 6;
    end
    m_cd    = ok ? 8 : (m_cd > 0 ? m_cd - 1 : 0);
    m_fired = ok;
    m_prev  = space;
  endfunction

  function automatic logic [31:0] exp_act();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_pos(input bit want_y);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++) v[10*i +: 10] = want_y ? 10'(m_y[i]) : 10'(m_x[i]);
    return v;
  endfunction

  task automatic step(input string tag);
    @(posedge frame_clk);
    model_edge(keycode, int'(ShipX), int'(ShipY), ShipColl, MissileHit);
    #1;
    if (Fired) hw_fires++;
    chk({tag, "_active"}, 32'(MissileActive), exp_act());
    chk({tag, "_xs"},     32'(MissileXs),     exp_pos(1'b0));
    chk({tag, "_ys"},     32'(MissileYs),     exp_pos(1'b1));
    chk({tag, "_fired"},  32'(Fired),         32'(m_fired));
  endtask

  task automatic pix(input string tag, input int dx, input int dy);
    int on, ox, oy;
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    #1;
    on = 0; ox = 0; oy = 0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (m_act[i] && dx >= m_x[i] && dx < (m_x[i] + 2) % 1024 &&
          dy >= m_y[i] && dy < (m_y[i] + 6) % 1024) begin
        on = 1; ox = dx - m_x[i]; oy = dy - m_y[i];
      end
    end
    chk({tag, "_on"},    32'(MissileOn),    32'(on));
    chk({tag, "_distx"}, 32'(MissileDistX), 32'(ox));
    chk({tag, "_disty"}, 32'(MissileDistY), 32'(oy));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, 32'(MissileActive), 0);
    chk({tag, "_xs"},     32'(MissileXs),     0);
    chk({tag, "_ys"},     32'(MissileYs),     0);
    chk({tag, "_fired"},  32'(Fired),         0);
    chk({tag, "_on"},     32'(MissileOn),     0);
    chk({tag, "_distx"},  32'(MissileDistX),  0);
    chk({tag, "_disty"},  32'(MissileDistY),  0);
  endtask

  initial begin
    Reset = 1'b1; keycode = '0; ShipX = '0; ShipY = '0; ShipColl = 1'b0;
    MissileHit = '0; DrawX = '0; DrawY = '0;
    model_reset();
    #2;
    chk_all_zero("reset");
    #6;
    Reset = 1'b0;

    // Fire from (320,400) and hold Space: exactly one missile
    ShipX = 10'd320; ShipY = 10'd400; keycode = 16'h002C;
    step("fire");
    chk("fire_x_const", 32'(MissileXs[9:0]), 327);
    chk("fire_y_const", 32'(MissileYs[9:0]), 394);
    pix("pix_in", 328, 399);
    chk("pix_in_const", 32'({MissileOn, MissileDistX, MissileDistY}), 32'({1'b1, 10'd1, 10'd5}));
    pix("pix_out", 329, 399);
    step("hold_first");
    chk("move_y_const", 32'(MissileYs[9:0]), 390);
    for (int i = 0; i < 18; i++) step("hold");
    chk("hold_one_missile", 32'(hw_fires), 1);

    // Clear slot 0, refire, then exercise the cooldown window
    keycode = '0; MissileHit = 2'b01;
    step("clear0");
    MissileHit = '0; keycode = 16'h2C00;
    step("e0");
    chk("e0_fired_const", 32'(Fired), 1);
    keycode = '0;
    step("e1"); step("e2");
    keycode = 16'h002C;
    step("e3");
    chk("cooldown_drop_const", 32'(Fired), 0);
    keycode = '0;
    for (int i = 0; i < 5; i++) step("e4_8");
    keycode = 16'h002C;
    step("e9");
    chk("slot1_fired_const", 32'(Fired), 1);
    chk("both_active_const", 32'(MissileActive), 2'b11);

    // Hit slot 0 while both full; the simultaneous fire is dropped
    keycode = '0;
    for (int i = 0; i < 9; i++) step("wait_cd");
    keycode = 16'h002C; MissileHit = 2'b01;
    step("hit_full");
    chk("hit_full_fired_const", 32'(Fired), 0);
    chk("hit_full_active_const", 32'(MissileActive), 2'b10);

    // Firing blocked by ship collision and by ShipY too small
    keycode = '0; MissileHit = '0;
    step("blk_rel0");
    keycode = 16'h002C; ShipColl = 1'b1;
    step("blk_coll");
    chk("blk_coll_const", 32'(Fired), 0);
    keycode = '0; ShipColl = 1'b0;
    step("blk_rel1");
    keycode = 16'h002C; ShipY = 10'd4;
    step("blk_y");
    chk("blk_y_const", 32'(Fired), 0);
    keycode = '0; ShipY = 10'd400;
    step("blk_rel2");
    keycode = 16'h002C;
    step("after_blk");
    chk("after_blk_fired_const", 32'(Fired), 1);

    // Reset mid-flight with Space held through release, then retire at the top
    pix("pre_rst", m_x[1], m_y[1]);
    #1 Reset = 1'b1;
    #1;
    model_reset();
    chk_all_zero("mid_reset");
    ShipY = 10'd9;
    #1 Reset = 1'b0;
    step("held_fire");
    chk("held_fire_const", 32'(Fired), 1);
    chk("retire_y_const", 32'(MissileYs[9:0]), 3);
    step("retire");
    chk("retire_active_const", 32'(MissileActive[0]), 0);
    chk("retire_nowrap_const", 32'(MissileYs[9:0]), 3);

    // Randomized frames
    for (int n = 0; n < 400; n++) begin
      int r;
      int s;
      r = int'($urandom_range(0, 3));
      case (r)
        0: keycode = '0;
        1: keycode = 16'h002C;
        2: keycode = 16'h2C00;
        default: keycode = 16'($urandom);
      endcase
      ShipX    = 10'($urandom_range(0, 1023));
      ShipY    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 479));
      ShipColl = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NUM; i++) MissileHit[i] = ($urandom_range(0, 7) == 0);
      step("rnd");
      s = int'($urandom_range(0, NUM - 1));
      pix("rnd_pix", (m_x[s] + int'($urandom_range(0, 3)) + 1023) % 1024,
                     (m_y[s] + int'($urandom_range(0, 7)) + 1023) % 1024);
      if ($urandom_range(0, 99) == 0) begin
        #1 Reset = 1'b1;
        #1;
        model_reset();
        chk_all_zero("rnd_reset");
        #1 Reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
